// File: rtl/uart_rx_if.sv
// Receive-side result bus: the word, its qualifier pulse, error flags and busy.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must accept a word on the data_valid pulse.
//
// Ports (modports):
//   master - driven by uart_rx: data_out, data_valid, parity_err, frame_err, busy
//   slave  - consumer view of the same signals (all inputs)
interface uart_rx_if #(
    parameter int FRAME_DATA = 8
);
    logic [FRAME_DATA-1:0] data_out;
    logic                  data_valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;

    modport master (
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        input data_out,
        input data_valid,
        input parity_err,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receive engine: oversampled start detect, LSB-first shift-in, optional even parity, stop check.
// Latency: word loaded CLKS_PER_BIT/2 + (FRAME_DATA+1+P)*CLKS_PER_BIT cycles after leaving IDLE.
// Backpressure: none; each word is offered for exactly one cycle on data_valid.
//
// Ports:
//   clk        - system clock, rising edge
//   rx_arst_n  - asynchronous active-low reset
//   rx_rst     - synchronous soft reset, active high, overrides everything else
//   rx_en      - allows start-bit detection in IDLE (an in-flight frame always completes)
//   rx_in      - asynchronous serial line, idle high
//   rx_bus     - result bus (uart_rx_if.master)
// Optional feature: define UART_RX_PARITY_EN to add the even-parity bit and make parity_err live.
module uart_rx #(
    parameter int FRAME_DATA   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rx_arst_n,
    input  logic       rx_rst,
    input  logic       rx_en,
    input  logic       rx_in,
    uart_rx_if.master  rx_bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(FRAME_DATA + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_DATA - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic                  sync1_q, rx_s;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FRAME_DATA-1:0] shift_q, shift_d;
    logic [FRAME_DATA-1:0] dout_q, dout_d;
    logic                  vld_q, vld_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    // Parity mismatch captured at the parity sample, published with the word at the stop sample.
    // Never set when parity is compiled out, so parity_err stays 0 in that build.
    logic                  pmis_q, pmis_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        pmis_d  = pmis_q;
        case (state_q)
            IDLE: begin
                if (rx_en && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Sample mid-bit; a high line here was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[FRAME_DATA-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    pmis_d  = (^shift_q) ^ rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                // Errored words are still delivered; the flags describe them.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    dout_d  = shift_q;
                    vld_d   = 1'b1;
                    ferr_d  = ~rx_s;
                    perr_d  = pmis_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pmis_q  <= 1'b0;
        end else if (rx_rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pmis_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rx_in;
            rx_s    <= sync1_q;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            pmis_q  <= pmis_d;
        end
    end

    assign rx_bus.data_out   = dout_q;
    assign rx_bus.data_valid = vld_q;
    assign rx_bus.parity_err = perr_q;
    assign rx_bus.frame_err  = ferr_q;
    // Combinational from state so it falls in the same cycle data_valid rises.
    assign rx_bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int FD  = 8;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Line falls at a negedge with cyc=c: T0 = c+3, word visible at cyc = T0 + CPB/2 + (FD+1+P)*CPB.
    localparam int LAT = 3 + CPB / 2 + (FD + 1 + P) * CPB;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic rx_arst_n = 1'b0;
    logic rx_rst = 1'b0;
    logic rx_en = 1'b0;
    logic rx_in = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    uart_rx_if #(.FRAME_DATA(FD)) bus ();

    uart_rx #(.FRAME_DATA(FD), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rx_arst_n (rx_arst_n),
        .rx_rst    (rx_rst),
        .rx_en     (rx_en),
        .rx_in     (rx_in),
        .rx_bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every data_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid data_out=%h cyc=%0d required=no_valid", bus.data_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.data_out !== mon_e.d) begin
                    failures++;
                    $display("FAIL data_out got=%h required=%h", bus.data_out, mon_e.d);
                end
                checks++;
                if (bus.frame_err !== mon_e.ferr) begin
                    failures++;
                    $display("FAIL frame_err got=%b required=%b data=%h", bus.frame_err, mon_e.ferr, mon_e.d);
                end
                checks++;
                if (bus.parity_err !== mon_e.perr) begin
                    failures++;
                    $display("FAIL parity_err got=%b required=%b data=%h", bus.parity_err, mon_e.perr, mon_e.d);
                end
                checks++;
                if (cyc !== mon_e.t) begin
                    failures++;
                    $display("FAIL valid_time got=%0d required=%0d data=%h", cyc, mon_e.t, mon_e.d);
                end
            end
        end
    end

    // Drives one frame starting at the current negedge; optionally records the expected word.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_b, input bit expect_out);
        exp_t e;
        logic [7:0] dv;
        dv = d;
        if (expect_out) begin
            e.d    = d;
            e.ferr = ~stop_b;
            e.perr = (P == 1) ? ((^d) ^ par) : 1'b0;
            e.t    = cyc + LAT;
            sb.push_back(e);
        end
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < FD; i++) begin
            rx_in = dv[i];
            repeat (CPB) @(negedge clk);
        end
        if (P == 1) begin
            rx_in = par;
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop_b;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.data_out, bus.data_valid, bus.parity_err, bus.frame_err, bus.busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b/%b required=all_zero",
                     bus.data_out, bus.data_valid, bus.parity_err, bus.frame_err, bus.busy);
        end
        @(negedge clk);
        rx_arst_n = 1'b1;
        rx_en = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b required=0", bus.busy);
        end
    endtask

    task automatic test_clean();
        @(negedge clk);
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
            begin
                repeat (2) @(negedge clk);
                checks++;
                if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_before_t0 got=%b required=0", bus.busy); end
                @(negedge clk);
                checks++;
                if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_rise got=%b required=1", bus.busy); end
                repeat (LAT - 4) @(negedge clk);
                checks++;
                if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_last got=%b required=1", bus.busy); end
                @(negedge clk);
                checks++;
                if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_fall got=%b required=0", bus.busy); end
            end
        join
        wait_drain();
    endtask

    task automatic test_glitch();
        bit seen;
        @(negedge clk);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got=%b required=1", bus.busy); end
        repeat (6) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_pre_sample got=%b required=1", bus.busy); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_drop got=%b required=0", bus.busy); end
        repeat (30) @(negedge clk);
        // With rx_en low a held-low line must not start a frame.
        rx_en = 1'b0;
        rx_in = 1'b0;
        seen = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (bus.busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rx_en_block busy_seen=%b required=0", seen); end
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        rx_en = 1'b1;
        wait_drain();
    endtask

    task automatic test_frame_err();
        @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_drain();
        repeat (40) @(negedge clk);
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        wait_drain();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        wait_drain();
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        wait_drain();
    endtask
`endif

    task automatic test_mid_reset(input bit use_async);
        @(negedge clk);
        fork
            send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
            begin
                repeat (4 * CPB + CPB / 2) @(negedge clk);
                if (use_async) begin
                    rx_arst_n = 1'b0;
                    #1;
                end else begin
                    rx_rst = 1'b1;
                    @(posedge clk);
                    #1;
                end
                checks++;
                if ({bus.data_out, bus.data_valid, bus.parity_err, bus.frame_err, bus.busy} !== '0) begin
                    failures++;
                    $display("FAIL mid_reset_outputs async=%0d got=%h/%b/%b/%b/%b required=all_zero", use_async,
                             bus.data_out, bus.data_valid, bus.parity_err, bus.frame_err, bus.busy);
                end
                @(negedge clk);
                rx_arst_n = 1'b1;
                rx_rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_glitch();
        test_frame_err();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_mid_reset(1'b1);
        test_mid_reset(1'b0);
        test_back_to_back();
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
